serial_rx: RTL

Single-line asynchronous serial receiver: it recovers framed, LSB-first data words from a one-bit line and presents each word in parallel with a one-cycle valid strobe. It is the receiving end of the team's serial link, sitting between the pad-level line input and any downstream consumer in the same clock domain. An optional even-parity check can be compiled in.

---
 rtl/serial_rx_pkg.sv | 30 +++
 rtl/serial_rx_if.sv | 33 +++
 rtl/serial_rx_bit_timer.sv | 35 +++
 rtl/serial_rx.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/serial_rx_pkg.sv
// serial_pkg: shared types and constants for the serial receiver.
// Optional feature macro: SERIAL_RX_PARITY_EN (adds the PARITY state).
package serial_pkg;

   localparam int DEF_DATA_W       = 8;
   localparam int DEF_CLKS_PER_BIT = 4;

   localparam logic IDLE_LEVEL  = 1'b1;
   localparam logic START_LEVEL = 1'b0;

`ifdef SERIAL_RX_PARITY_EN
   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      WAIT_HIGH
   } rx_state_t;
`else
   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } rx_state_t;
`endif

endpackage

// File: rtl/serial_rx_if.sv
// serial_rx_if: line input plus parallel word/strobe outputs of the receiver.
// Optional feature macro: SERIAL_RX_PARITY_EN (no effect on this interface).
interface serial_rx_if
   import serial_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
);

   logic              rx_in;
   logic [DATA_W-1:0] data_out;
   logic              valid_out;
   logic              err_out;
   logic              busy_out;

   // master drives the line and consumes the recovered words
   modport master (
      output rx_in,
      input  data_out,
      input  valid_out,
      input  err_out,
      input  busy_out
   );

   // slave is the receiver itself
   modport slave (
      input  rx_in,
      output data_out,
      output valid_out,
      output err_out,
      output busy_out
   );

endinterface

// File: rtl/serial_rx_bit_timer.sv
// bit_timer: phase counter that marks the middle and the end of a bit period.
// Optional feature macro: SERIAL_RX_PARITY_EN (no effect on this module).
module bit_timer
   import serial_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
)(
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic half_tick,
   output logic full_tick
);

   localparam int PW = $clog2(CLKS_PER_BIT);
   localparam logic [PW-1:0] HALF_LAST = PW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [PW-1:0] FULL_LAST = PW'(CLKS_PER_BIT - 1);

   logic [PW-1:0] r_phase;

   // Count cycles within a bit; wrap at the end of the period or restart on clear
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_phase <= '0;
      end else if (clear || (r_phase == FULL_LAST)) begin
         r_phase <= '0;
      end else begin
         r_phase <= r_phase + 1'b1;
      end
   end

   assign half_tick = (r_phase == HALF_LAST);
   assign full_tick = (r_phase == FULL_LAST);

endmodule

// File: rtl/serial_rx.sv
// serial_rx: framed LSB-first serial receiver with one-cycle valid/error strobes.
// Optional feature macro: SERIAL_RX_PARITY_EN (even parity bit before the stop bit).
module serial_rx
   import serial_pkg::*;
#(
   parameter int DATA_W       = DEF_DATA_W,
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
)(
   input  logic       clk,
   input  logic       reset,
   serial_rx_if.slave bus
);

   localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

   rx_state_t         r_state;
   logic [DATA_W-1:0] r_shift;
   logic [DATA_W-1:0] r_data;
   logic [BW-1:0]     r_bit_cnt;
   logic              r_valid;
   logic              r_err;
   logic              r_busy;

   logic              w_clear;
   logic              w_half;
   logic              w_full;
   logic              w_par_ok;
   logic [DATA_W-1:0] w_shift_next;

   // New bits enter at the MSB so the first (LSB) bit ends up at position 0
   generate
      if (DATA_W == 1) begin : g_shift_one
         assign w_shift_next = bus.rx_in;
      end else begin : g_shift_multi
         assign w_shift_next = {bus.rx_in, r_shift[DATA_W-1:1]};
      end
   endgenerate

   // The timer is held at zero while idle so edge 0 starts the start-bit count,
   // and restarted once the start bit is confirmed so data samples land mid-bit
   assign w_clear = (r_state == IDLE) || ((r_state == START) && w_half);

   bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_bit_timer (
      .clk       (clk),
      .reset     (reset),
      .clear     (w_clear),
      .half_tick (w_half),
      .full_tick (w_full)
   );

`ifdef SERIAL_RX_PARITY_EN
   logic r_par_err;
   assign w_par_ok = ~r_par_err;
`else
   assign w_par_ok = 1'b1;
`endif

   // Frame state machine: sampling, shifting, word capture and strobes
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_shift   <= '0;
         r_data    <= '0;
         r_bit_cnt <= '0;
         r_valid   <= 1'b0;
         r_err     <= 1'b0;
         r_busy    <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
         r_par_err <= 1'b0;
`endif
      end else begin
         r_valid <= 1'b0;
         r_err   <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.rx_in == START_LEVEL) begin
                  r_state   <= START;
                  r_busy    <= 1'b1;
                  r_bit_cnt <= '0;
               end
            end
            START: begin
               if (w_half) begin
                  if (bus.rx_in == START_LEVEL) begin
                     r_state <= DATA;
                  end else begin
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                  end
               end
            end
            DATA: begin
               if (w_full) begin
                  r_shift   <= w_shift_next;
                  r_bit_cnt <= r_bit_cnt + 1'b1;
                  if (r_bit_cnt == LAST_BIT) begin
`ifdef SERIAL_RX_PARITY_EN
                     r_state <= PARITY;
`else
                     r_state <= STOP;
`endif
                  end
               end
            end
`ifdef SERIAL_RX_PARITY_EN
            PARITY: begin
               if (w_full) begin
                  r_par_err <= ^{r_shift, bus.rx_in};
                  r_state   <= STOP;
               end
            end
`endif
            STOP: begin
               if (w_full) begin
                  if (bus.rx_in == IDLE_LEVEL) begin
                     if (w_par_ok) begin
                        r_data  <= r_shift;
                        r_valid <= 1'b1;
                     end else begin
                        r_err <= 1'b1;
                     end
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                  end else begin
                     r_err   <= 1'b1;
                     r_state <= WAIT_HIGH;
                  end
               end
            end
            WAIT_HIGH: begin
               if (bus.rx_in == IDLE_LEVEL) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.data_out  = r_data;
   assign bus.valid_out = r_valid;
   assign bus.err_out   = r_err;
   assign bus.busy_out  = r_busy;

endmodule
